tdm_demux: RTL and testbench

- Time-division demultiplexer: receives one shared serial stream of WIDTH-bit samples, built by a mux-based TDM serializer, and routes each sample to its channel slot.
- Reassembles one complete frame of CHANNELS samples, then presents it as a parallel bus with a one-cycle valid pulse.
- Receive end of the team's select-driven multiplexed datapath; sits between the shared bus and the per-channel adder/ALU operand registers.

---
 rtl/tdm_demux.sv | 138 +++++++++++++
 tb/tb_tdm_demux.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux
//   Receive side of a TDM link. A shared serial stream of WIDTH-bit samples,
//   framed by a sync flag on channel 0, is demultiplexed into a shadow buffer
//   and handed over as one parallel frame when the last channel arrives.
//
//   State table:
//      state   | meaning
//      HUNT    | unaligned, waiting for a sync sample
//      FILL    | frame partially received, cnt_q = next channel index
//      ALIGNED | frame just completed, next valid sample must carry sync
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   in_sync/in_data qualify this cycle
//   in_sync    marks channel 0 of a frame
//   in_data    sample value
//   out_data   last complete frame, channel k at [k*WIDTH +: WIDTH]
//   out_valid  one-cycle pulse when out_data takes a new frame
//   frame_err  one-cycle pulse on a premature or missing sync
//   busy       high while a frame is partially received
module tdm_demux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic                      in_sync,
   input  logic [WIDTH-1:0]          in_data,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      out_valid,
   output logic                      frame_err,
   output logic                      busy
);

   localparam int            CW      = $clog2(CHANNELS);
   localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      FILL    = 2'd1,
      ALIGNED = 2'd2
   } state_t;

   state_t                      state_q,     state_d;
   logic [CW-1:0]               cnt_q,       cnt_d;
   logic [CHANNELS*WIDTH-1:0]   shadow_q,    shadow_d;
   logic [CHANNELS*WIDTH-1:0]   out_data_q,  out_data_d;
   logic                        out_valid_q, out_valid_d;
   logic                        frame_err_q, frame_err_d;
   logic                        busy_q,      busy_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      frame_err_d = 1'b0;

      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (in_sync) begin
                  shadow_d[WIDTH-1:0] = in_data;
                  cnt_d               = CW'(1);
                  state_d             = FILL;
               end
            end

            FILL: begin
               if (in_sync) begin
                  // Premature sync: restart the frame with this sample as ch0.
                  frame_err_d         = 1'b1;
                  shadow_d[WIDTH-1:0] = in_data;
                  cnt_d               = CW'(1);
               end else begin
                  shadow_d[cnt_q*WIDTH +: WIDTH] = in_data;
                  if (cnt_q == LAST_CH) begin
                     // Copy includes the sample accepted at this same edge.
                     out_data_d  = shadow_d;
                     out_valid_d = 1'b1;
                     cnt_d       = '0;
                     state_d     = ALIGNED;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end

            ALIGNED: begin
               if (in_sync) begin
                  shadow_d[WIDTH-1:0] = in_data;
                  cnt_d               = CW'(1);
                  state_d             = FILL;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = HUNT;
               end
            end

            default: begin
               state_d = HUNT;
               cnt_d   = '0;
            end
         endcase
      end

      busy_d = (state_d == FILL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= HUNT;
         cnt_q       <= '0;
         shadow_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed testbench for tdm_demux (WIDTH=8, CHANNELS=4).
module tb_tdm_demux;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;

   logic                      clk;
   logic                      reset;
   logic                      in_valid;
   logic                      in_sync;
   logic [WIDTH-1:0]          in_data;
   logic [CHANNELS*WIDTH-1:0] out_data;
   logic                      out_valid;
   logic                      frame_err;
   logic                      busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        v;
      logic        s;
      logic [7:0]  d;
      logic        ev;
      logic        eb;
      logic        ee;
      logic [31:0] ed;
   } step_t;

   tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_sync   (in_sync),
      .in_data   (in_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one input cycle and return 1 time unit after the accepting edge.
   task automatic drive(input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      in_valid = v;
      in_sync  = s;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset out_data: got %h expected %h", out_data, 32'h0); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b expected 0", frame_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic;
      step_t tbl[5] = '{
         '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0, 32'h44332211},
         '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h44332211}
      };
      for (int i = 0; i < 5; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].d);
         checks++; if (out_valid !== tbl[i].ev) begin errors++; $display("FAIL basic out_valid step %0d: got %b expected %b", i, out_valid, tbl[i].ev); end
         checks++; if (busy !== tbl[i].eb) begin errors++; $display("FAIL basic busy step %0d: got %b expected %b", i, busy, tbl[i].eb); end
         checks++; if (frame_err !== tbl[i].ee) begin errors++; $display("FAIL basic frame_err step %0d: got %b expected %b", i, frame_err, tbl[i].ee); end
         checks++; if (out_data !== tbl[i].ed) begin errors++; $display("FAIL basic out_data step %0d: got %h expected %h", i, out_data, tbl[i].ed); end
      end
   endtask

   task automatic test_back_to_back;
      step_t tbl[12] = '{
         '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h44332211},
         '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h44332211},
         '{1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 32'h44332211},
         '{1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 32'h44332211},
         '{1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 32'h44332211},
         '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h44332211},
         '{1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0, 32'h44332211},
         '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 32'h44332211},
         '{1'b1, 1'b0, 8'hB2, 1'b0, 1'b1, 1'b0, 32'h44332211},
         '{1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 32'h44332211},
         '{1'b1, 1'b0, 8'hD4, 1'b1, 1'b0, 1'b0, 32'hD4C3B2A1},
         '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'hD4C3B2A1}
      };
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].d);
         checks++; if (out_valid !== tbl[i].ev) begin errors++; $display("FAIL b2b out_valid step %0d: got %b expected %b", i, out_valid, tbl[i].ev); end
         checks++; if (busy !== tbl[i].eb) begin errors++; $display("FAIL b2b busy step %0d: got %b expected %b", i, busy, tbl[i].eb); end
         checks++; if (frame_err !== tbl[i].ee) begin errors++; $display("FAIL b2b frame_err step %0d: got %b expected %b", i, frame_err, tbl[i].ee); end
         checks++; if (out_data !== tbl[i].ed) begin errors++; $display("FAIL b2b out_data step %0d: got %h expected %h", i, out_data, tbl[i].ed); end
      end
   endtask

   task automatic test_hunt;
      step_t tbl[6] = '{
         '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 32'h00000000},
         '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 32'h04030201}
      };
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].d);
         checks++; if (out_valid !== tbl[i].ev) begin errors++; $display("FAIL hunt out_valid step %0d: got %b expected %b", i, out_valid, tbl[i].ev); end
         checks++; if (busy !== tbl[i].eb) begin errors++; $display("FAIL hunt busy step %0d: got %b expected %b", i, busy, tbl[i].eb); end
         checks++; if (frame_err !== tbl[i].ee) begin errors++; $display("FAIL hunt frame_err step %0d: got %b expected %b", i, frame_err, tbl[i].ee); end
         checks++; if (out_data !== tbl[i].ed) begin errors++; $display("FAIL hunt out_data step %0d: got %h expected %h", i, out_data, tbl[i].ed); end
      end
   endtask

   task automatic test_premature_sync;
      step_t tbl[6] = '{
         '{1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 32'h04030201},
         '{1'b1, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 32'h04030201},
         '{1'b1, 1'b1, 8'h30, 1'b0, 1'b1, 1'b1, 32'h04030201},
         '{1'b1, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 32'h04030201},
         '{1'b1, 1'b0, 8'h50, 1'b0, 1'b1, 1'b0, 32'h04030201},
         '{1'b1, 1'b0, 8'h60, 1'b1, 1'b0, 1'b0, 32'h60504030}
      };
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].d);
         checks++; if (out_valid !== tbl[i].ev) begin errors++; $display("FAIL premature out_valid step %0d: got %b expected %b", i, out_valid, tbl[i].ev); end
         checks++; if (busy !== tbl[i].eb) begin errors++; $display("FAIL premature busy step %0d: got %b expected %b", i, busy, tbl[i].eb); end
         checks++; if (frame_err !== tbl[i].ee) begin errors++; $display("FAIL premature frame_err step %0d: got %b expected %b", i, frame_err, tbl[i].ee); end
         checks++; if (out_data !== tbl[i].ed) begin errors++; $display("FAIL premature out_data step %0d: got %h expected %h", i, out_data, tbl[i].ed); end
      end
   endtask

   task automatic test_missing_sync;
      // 0x78 probes that the missing sync dropped back to HUNT: a second
      // unsynced sample must be silent there.
      step_t tbl[6] = '{
         '{1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 32'h60504030},
         '{1'b1, 1'b0, 8'h78, 1'b0, 1'b0, 1'b0, 32'h60504030},
         '{1'b1, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 32'h60504030},
         '{1'b1, 1'b0, 8'h82, 1'b0, 1'b1, 1'b0, 32'h60504030},
         '{1'b1, 1'b0, 8'h83, 1'b0, 1'b1, 1'b0, 32'h60504030},
         '{1'b1, 1'b0, 8'h84, 1'b1, 1'b0, 1'b0, 32'h84838281}
      };
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].d);
         checks++; if (out_valid !== tbl[i].ev) begin errors++; $display("FAIL missing out_valid step %0d: got %b expected %b", i, out_valid, tbl[i].ev); end
         checks++; if (busy !== tbl[i].eb) begin errors++; $display("FAIL missing busy step %0d: got %b expected %b", i, busy, tbl[i].eb); end
         checks++; if (frame_err !== tbl[i].ee) begin errors++; $display("FAIL missing frame_err step %0d: got %b expected %b", i, frame_err, tbl[i].ee); end
         checks++; if (out_data !== tbl[i].ed) begin errors++; $display("FAIL missing out_data step %0d: got %h expected %h", i, out_data, tbl[i].ed); end
      end
   endtask

   task automatic test_async_reset;
      step_t tbl[6] = '{
         '{1'b1, 1'b0, 8'hE3, 1'b0, 1'b0, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'hE4, 1'b0, 1'b0, 1'b0, 32'h00000000},
         '{1'b1, 1'b1, 8'hF1, 1'b0, 1'b1, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'hF2, 1'b0, 1'b1, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'hF3, 1'b0, 1'b1, 1'b0, 32'h00000000},
         '{1'b1, 1'b0, 8'hF4, 1'b1, 1'b0, 1'b0, 32'hF4F3F2F1}
      };
      drive(1'b1, 1'b1, 8'hE1);
      drive(1'b1, 1'b0, 8'hE2);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL async_reset pre busy: got %b expected 1", busy); end
      // Reset is raised and released between edges; outputs must clear anyway.
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL async_reset out_data: got %h expected %h", out_data, 32'h0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset busy: got %b expected 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset out_valid: got %b expected 0", out_valid); end
      #1;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].d);
         checks++; if (out_valid !== tbl[i].ev) begin errors++; $display("FAIL async_reset out_valid step %0d: got %b expected %b", i, out_valid, tbl[i].ev); end
         checks++; if (busy !== tbl[i].eb) begin errors++; $display("FAIL async_reset busy step %0d: got %b expected %b", i, busy, tbl[i].eb); end
         checks++; if (frame_err !== tbl[i].ee) begin errors++; $display("FAIL async_reset frame_err step %0d: got %b expected %b", i, frame_err, tbl[i].ee); end
         checks++; if (out_data !== tbl[i].ed) begin errors++; $display("FAIL async_reset out_data step %0d: got %h expected %h", i, out_data, tbl[i].ed); end
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      in_data  = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_hunt();
      test_premature_sync();
      test_missing_sync();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
